// File: rtl/op_enc_pkg.sv
// Shared definitions for the operation-request encoder.
//   - OP_CODE_*   : operation codes understood by the selector (one select line each)
//   - op_state_e  : encoder FSM states
//   - TMO_CNT_W   : width of the WAIT_DONE timeout counter
//   - DEB_CNT_W   : width of the debounce counter (OP_ENC_DEBOUNCE_EN builds only)
package op_enc_pkg;

  localparam logic [2:0] OP_CODE_IDLE = 3'b000;
  localparam logic [2:0] OP_CODE_3    = 3'b001;
  localparam logic [2:0] OP_CODE_2    = 3'b010;
  localparam logic [2:0] OP_CODE_1    = 3'b011;
  localparam logic [2:0] OP_CODE_0    = 3'b101;

  localparam int unsigned TMO_CNT_W = 8;
  localparam int unsigned DEB_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEBOUNCE  = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } op_state_e;

endpackage

// File: rtl/op_prio_enc.sv
// Combinational 4-to-3 priority encoder for operation requests.
//   req  : request lines, req[3] highest priority
//   code : operation code of the winning request (OP_CODE_IDLE when none)
//   hit  : at least one request is high
module op_prio_enc
  import op_enc_pkg::*;
(
  input  logic [3:0] req,
  output logic [2:0] code,
  output logic       hit
);

  always_comb begin
    hit  = |req;
    code = OP_CODE_IDLE;
    if (req[3])      code = OP_CODE_3;
    else if (req[2]) code = OP_CODE_2;
    else if (req[1]) code = OP_CODE_1;
    else if (req[0]) code = OP_CODE_0;
  end

endmodule

// File: rtl/op_request_encoder.sv
// Front end that turns four operation-request lines into a registered
// 3-bit operation code for the calculator's operation selector.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level requests, req[3] highest priority
//   done       : datapath completion pulse, honoured only while op_valid
//   op_code    : encoded operation
//   op_valid   : op_code is live
//   busy       : FSM is not in IDLE
//   err        : one-cycle pulse when WAIT_DONE times out
// Optional feature: define OP_ENC_DEBOUNCE_EN to require DEBOUNCE_CYCLES
// stable samples of the encoded request before it is issued.
module op_request_encoder
  import op_enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [2:0] op_code,
  output logic       op_valid,
  output logic       busy,
  output logic       err
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("op_request_encoder: DEBOUNCE_CYCLES or TIMEOUT_CYCLES out of range");
  end

  // Abort on the cycle whose count (including itself) reaches TIMEOUT_CYCLES,
  // so op_valid is high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  op_state_e             state_q, state_d;
  logic [2:0]            code_q, code_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [TMO_CNT_W-1:0]  tmo_q, tmo_d;
  logic [2:0]            enc_code;
  logic                  enc_hit;

`ifdef OP_ENC_DEBOUNCE_EN
  localparam logic [DEB_CNT_W-1:0] DEB_LIMIT = DEB_CNT_W'(DEBOUNCE_CYCLES);
  logic [2:0]           cap_q, cap_d;
  logic [DEB_CNT_W-1:0] deb_q, deb_d;
`endif

  op_prio_enc u_prio (
    .req  (req),
    .code (enc_code),
    .hit  (enc_hit)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    tmo_d   = tmo_q;
`ifdef OP_ENC_DEBOUNCE_EN
    cap_d   = cap_q;
    deb_d   = deb_q;
`endif
    case (state_q)
      IDLE: begin
        if (enc_hit) begin
`ifdef OP_ENC_DEBOUNCE_EN
          state_d = DEBOUNCE;
          cap_d   = enc_code;
          deb_d   = DEB_CNT_W'(1);
`else
          state_d = ISSUE;
          code_d  = enc_code;
`endif
        end
      end
`ifdef OP_ENC_DEBOUNCE_EN
      DEBOUNCE: begin
        if (!enc_hit) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (enc_code != cap_q) begin
          cap_d = enc_code;
          deb_d = DEB_CNT_W'(1);
        end else if (deb_q == DEB_LIMIT) begin
          state_d = ISSUE;
          code_d  = cap_q;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + DEB_CNT_W'(1);
        end
      end
`endif
      ISSUE: begin
        state_d = WAIT_DONE;
        valid_d = 1'b1;
        tmo_d   = '0;
      end
      WAIT_DONE: begin
        // done wins over a simultaneous timeout.
        if (done && valid_q) begin
          state_d = RELEASE;
          valid_d = 1'b0;
        end else if (tmo_q == TMO_LIMIT) begin
          state_d = RELEASE;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!enc_hit) begin
          state_d = IDLE;
          code_d  = OP_CODE_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = OP_CODE_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= OP_CODE_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
`ifdef OP_ENC_DEBOUNCE_EN
      cap_q   <= OP_CODE_IDLE;
      deb_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
`ifdef OP_ENC_DEBOUNCE_EN
      cap_q   <= cap_d;
      deb_q   <= deb_d;
`endif
    end
  end

  assign op_code  = code_q;
  assign op_valid = valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: doc/op_request_encoder.md
# op_request_encoder

- Sequential front end that turns four operation-request lines into the 3-bit operation code consumed by the operation selector (decoder) of the calculator datapath.
- Priority-encodes the requests and registers the winning code.
- Holds the code with a valid flag until the datapath signals completion, then waits for all requests to drop before accepting the next one.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical samples needed before issue. Used only with the debounce feature; legal range 1–15.
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT_DONE before abort. Legal range 1–255; the counter is 8 bits.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  level operation requests; req[3] highest priority. Synchronous to clk.
- done  input  1  datapath completion pulse; qualified by op_valid.
- op_code  output  3  encoded operation for the selector.
- op_valid  output  1  op_code is live; downstream must ignore op_code when low.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle pulse on timeout abort.

## Operation

- Code map, chosen so the selector drives exactly one select line:
  - req[3] → 3'b001 (selects line 3)
  - req[2] → 3'b010 (selects line 2)
  - req[1] → 3'b011 (selects line 1)
  - req[0] → 3'b101 (selects line 0)
- Idle code is 3'b000.
- When several requests are high, the highest index wins. Lower-priority requests are discarded, not queued.
- States:
  - IDLE: op_valid=0, op_code=000. If any req bit is high → ISSUE (or DEBOUNCE when the feature is compiled in), latching the encoded code.
  - ISSUE: one cycle. op_valid and op_code are driven from registers. Go to WAIT_DONE; the timeout counter is cleared.
  - WAIT_DONE: op_valid=1 and op_code stays stable.
    - done=1 → RELEASE; op_valid=0 from the next cycle.
    - Timeout counter reaches TIMEOUT_CYCLES → RELEASE with err=1 for one cycle; op_valid=0.
    - done takes precedence when it arrives on the same cycle as the timeout.
  - RELEASE: op_valid=0. Stay until req==0 is sampled, then → IDLE.
- Changes on req during ISSUE, WAIT_DONE or DEBOUNCE (after the latch) do not alter op_code.
- done is ignored whenever op_valid=0.

## Timing

- Reset values, asynchronous: state=IDLE, op_code=000, op_valid=0, busy=0, err=0. All counters are 0.
- Reset asserted mid-operation aborts immediately. No err pulse is generated.
- Without debounce:
  - req sampled high at edge k → op_valid=1 after edge k+1.
  - Latency is one cycle.
- done sampled at edge m → op_valid=0 after edge m.
- A request still held at done is not reissued. At least one cycle of req==0 is required before the next issue.
- req returning high on the same edge RELEASE exits to IDLE is sampled in IDLE at the following edge.
- All outputs are registered; there is no combinational path from req or done to any output.

## Configuration

- Macro: OP_ENC_DEBOUNCE_EN.
- Defined: IDLE → DEBOUNCE on any request, capturing the encoded code.
  - Each cycle the encoded request equals the capture, the counter increments.
  - If the encoded request differs but is non-zero, the new code is recaptured and the counter resets to 1.
  - If all requests are low, return to IDLE.
  - The count reaching DEBOUNCE_CYCLES → ISSUE. Latency from the first sample is DEBOUNCE_CYCLES+1 cycles.
  - busy=1 in DEBOUNCE.
- Not defined: the DEBOUNCE state and its counter are absent, and the DEBOUNCE_CYCLES parameter is unused.

## Structure

- Package op_enc_pkg:
  - Code constants OP_CODE_3/2/1/0 and OP_CODE_IDLE.
  - State enumeration: IDLE, DEBOUNCE, ISSUE, WAIT_DONE, RELEASE.
  - Timeout counter width constant.
- Sub-module op_prio_enc: combinational 4-to-3 priority encoder with a hit flag. It is instantiated once and also reused by the bench as its reference model.

## Test plan

- Reset, no debounce: hold rst_n=0 with req=4'b1111 → op_code=000, op_valid=0, busy=0. Release reset with req=4'b0100 → op_code=010 and op_valid=1 one cycle later.
- Priority: req=4'b1011 → op_code=001. A done pulse, then hold req → op_valid stays 0 in RELEASE. req=0 for one cycle, then req=4'b0011 → op_code=011.
- Timeout: TIMEOUT_CYCLES=8, issue req[0] → op_code=101. done is never asserted → err pulses once, op_valid drops, state is RELEASE.
- Ignored inputs:
  - done pulses while in IDLE → no state change.
  - req changes during WAIT_DONE → op_code holds.
  - done and the timeout on the same cycle → no err.
- Debounce with OP_ENC_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
  - A 3-cycle glitch on req[2] → nothing issued.
  - Holding req[1] → op_valid after 5 cycles with op_code=011.
- Mid-operation reset: assert rst_n=0 during WAIT_DONE → outputs return to reset values asynchronously and err stays 0.
